// File: rtl/screen_fill_controller.sv
`default_nettype none
// ============================================================================
// Module   : screen_fill_controller
// Purpose  : Sequences character-buffer writes and burst fills (scroll/clear)
//            and owns the hardware-scroll first-row register.
// Revision : 1.0  initial release
// ============================================================================
module screen_fill_controller #(
    parameter int         COL_BITS  = 6,
    parameter int         ROW_BITS  = 4,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic                         clk,
    input  logic                         clr,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [ROW_BITS+COL_BITS-1:0] cmd_addr,
    input  logic [7:0]                   cmd_char,
    output logic [7:0]                   new_char,
    output logic [ROW_BITS+COL_BITS-1:0] new_char_address,
    output logic                         new_char_wen,
    output logic [ROW_BITS-1:0]          new_first_row,
    output logic                         new_first_row_wen,
    output logic                         busy
);

    localparam int c_ADDR_W = ROW_BITS + COL_BITS;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FILL   = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    localparam logic [1:0] c_OP_WRITE  = 2'b00;
    localparam logic [1:0] c_OP_SCROLL = 2'b01;
    localparam logic [1:0] c_OP_CLEAR  = 2'b10;

    localparam logic c_MODE_ROW = 1'b0;
    localparam logic c_MODE_ALL = 1'b1;

    logic [1:0]          state_q, state_d;
    logic                mode_q, mode_d;
    logic [c_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]          char_q, char_d;
    logic                wen_q, wen_d;
    logic [ROW_BITS-1:0] fr_q, fr_d;
    logic                fr_wen_q, fr_wen_d;
    logic                busy_q, busy_d;
    logic                w_last;

    // The write-address register doubles as the fill counter: during a burst
    // it always holds the address being written in the current cycle.
    assign w_last = (mode_q == c_MODE_ALL) ? (&addr_q) : (&addr_q[COL_BITS-1:0]);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        char_d   = char_q;
        wen_d    = 1'b0;
        fr_d     = fr_q;
        fr_wen_d = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        c_OP_WRITE: begin
                            addr_d = cmd_addr;
                            char_d = cmd_char;
                            wen_d  = 1'b1;
                        end
                        c_OP_SCROLL: begin
                            addr_d  = {fr_q, {COL_BITS{1'b0}}};
                            char_d  = FILL_CHAR;
                            wen_d   = 1'b1;
                            mode_d  = c_MODE_ROW;
                            state_d = c_FILL;
                        end
                        c_OP_CLEAR: begin
                            addr_d  = '0;
                            char_d  = FILL_CHAR;
                            wen_d   = 1'b1;
                            mode_d  = c_MODE_ALL;
                            state_d = c_FILL;
                        end
                        default: ;
                    endcase
                end
            end
            c_FILL: begin
                if (w_last) begin
                    state_d  = c_FINISH;
                    fr_d     = (mode_q == c_MODE_ROW) ? fr_q + 1'b1 : '0;
                    fr_wen_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                    wen_d  = 1'b1;
                end
            end
            c_FINISH: state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase
        busy_d = (state_d != c_IDLE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q  <= c_IDLE;
            mode_q   <= c_MODE_ROW;
            addr_q   <= '0;
            char_q   <= '0;
            wen_q    <= 1'b0;
            fr_q     <= '0;
            fr_wen_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_q   <= addr_d;
            char_q   <= char_d;
            wen_q    <= wen_d;
            fr_q     <= fr_d;
            fr_wen_q <= fr_wen_d;
            busy_q   <= busy_d;
        end
    end

    assign cmd_ready         = (state_q == c_IDLE);
    assign new_char          = char_q;
    assign new_char_address  = addr_q;
    assign new_char_wen      = wen_q;
    assign new_first_row     = fr_q;
    assign new_first_row_wen = fr_wen_q;
    assign busy              = busy_q;

endmodule
`default_nettype wire

// File: doc/screen_fill_controller.md
# screen_fill_controller

Sequences all writes into the character buffer and owns its first-row (hardware scroll) register. It accepts three command types from the command handler: single-character writes, scroll-up, and clear-screen. For scroll and clear it generates burst fills with the fill character, and stalls the command stream while a burst runs. It sits between `command_handler` and the `char_generator` buffer write / first-row ports, in the pixel-clock domain.

## Interface
Parameters:
- `COL_BITS`, 6: column address width; 64 columns per row.
- `ROW_BITS`, 4: row address width; 16 physical rows.
- `FILL_CHAR`, 8'h20: code written by fills (space).

Ports:
- `clk`  in  1  pixel clock; the block's only clock.
- `clr`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `cmd_op`  in  2  operation: 00 write char, 01 scroll up, 10 clear screen, 11 no-op.
- `cmd_addr`  in  ROW_BITS+COL_BITS  physical buffer address, as {row, col}; used by op 00 only.
- `cmd_char`  in  8  character code; used by op 00 only.
- `new_char`  out  8  buffer write data.
- `new_char_address`  out  ROW_BITS+COL_BITS  buffer write address.
- `new_char_wen`  out  1  buffer write strobe, one cycle per write.
- `new_first_row`  out  ROW_BITS  current first displayed row; always driven from the internal register.
- `new_first_row_wen`  out  1  one-cycle pulse when `new_first_row` changes.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- A command is accepted on any rising edge where `cmd_valid && cmd_ready`.
- `cmd_ready` = (state == IDLE), combinational. It is 1 immediately after reset.
- States: IDLE, FILL, FINISH.
- IDLE behaviour per op:
  - op 00: register `cmd_addr` and `cmd_char` onto the write outputs and pulse `new_char_wen`. State stays IDLE.
  - op 01 (scroll): load the fill counter with {first_row, 0}, set mode=ROW, go to FILL.
  - op 10 (clear): load the fill counter with 0, set mode=ALL, go to FILL.
  - op 11: accepted and discarded. No output activity.
- FILL, every cycle:
  - Drive `new_char_address` = counter, `new_char` = FILL_CHAR, `new_char_wen` = 1.
  - Increment the counter.
  - Mode ROW: after the write whose column field is all-ones, go to FINISH. The row field never changes.
  - Mode ALL: after the write to address all-ones, go to FINISH.
- FINISH, one cycle:
  - Mode ROW: first_row <= first_row + 1, wrapping modulo 2^ROW_BITS (15 -> 0).
  - Mode ALL: first_row <= 0.
  - `new_first_row_wen` = 1 in this cycle, with the new value already on `new_first_row`. Then go to IDLE.
- Effect of scroll: the old top row is blanked and then becomes the bottom row.
- Arithmetic: the fill counter is ROW_BITS+COL_BITS wide. The first_row increment is ROW_BITS wide and wraps silently.
- `cmd_op`, `cmd_addr` and `cmd_char` are ignored whenever `cmd_ready` = 0. A command held with `cmd_valid` high through a burst is accepted in the first IDLE cycle.
- Reset (`clr` high, asynchronous), including mid-burst:
  - state = IDLE, first_row = 0, counter = 0.
  - All outputs 0 except `cmd_ready` = 1.
  - No write strobe or first_row pulse is emitted for the aborted burst.

## Timing
- All outputs except `cmd_ready` are registered.
- Char write accepted at edge N: `new_char_wen` is high in cycle N+1 only. Back-to-back writes are sustained at one per cycle.
- Scroll accepted at edge N:
  - Fill writes occupy cycles N+1..N+64, at addresses {R,0}..{R,63}, where R is the old first_row.
  - FINISH is cycle N+65: `new_first_row` = R+1 and `new_first_row_wen` = 1.
  - `cmd_ready` goes high again in cycle N+66.
- Clear accepted at edge N:
  - Fill writes occupy cycles N+1..N+1024, at addresses 0..1023.
  - FINISH is cycle N+1025, with `new_first_row` = 0 and the pulse.
  - `cmd_ready` goes high in cycle N+1026.
- No-op accepted at edge N: `cmd_ready` is still 1 in cycle N+1.
- `new_char_wen` and `new_first_row_wen` are never high in the same cycle.
- `busy` = ~`cmd_ready`, registered-equivalent: it is high from cycle N+1 through FINISH inclusive.

## Test plan
- Reset release, then write op 00 with addr 10'h041 and char 8'h41 held one cycle -> exactly one `new_char_wen` pulse on the next cycle with addr 041 and data 41; `new_first_row` = 0 and `new_first_row_wen` = 0 throughout.
- Three back-to-back op 00 commands (addr 1/2/3, chars 'a'/'b'/'c') -> three consecutive wen cycles in order; `cmd_ready` stays 1.
- first_row = 0, scroll accepted -> 64 writes of 8'h20 to addresses 0..63, then `new_first_row_wen` with value 1; `cmd_ready` is low for 65 cycles. Repeat 16 scrolls -> the 16th yields value 0 (wrap), and its fill row is 15.
- Clear issued after 5 scrolls -> 1024 writes of 8'h20 covering 0..1023 with no gaps or repeats, then a `new_first_row_wen` pulse with value 0.
- Op 00 held valid during a scroll burst -> it is accepted only at cycle N+66, and its write appears at N+67; it is never interleaved with fill writes.
- `clr` asserted at fill write 30 of a clear -> all strobes drop immediately; `new_first_row` = 0; `cmd_ready` = 1; no FINISH pulse after `clr` deasserts. Op 11 afterwards produces no output activity.
